polar_to_xy_15: RTL and testbench

- Sequential polar-to-Cartesian converter for the tracking display.
- Takes a range magnitude r and an angle index (15° steps, full 0–345° circle); produces signed x = r·cos θ and y = r·sin θ.
- Uses one shared iterative shift-add multiplier and a Q1.16 quarter-wave sine LUT, with valid/ready on both sides.
- Sits between the ultrasound range/angle capture logic and the display coordinate mapper.

---
 rtl/polar_to_xy_15.sv | 147 ++++++++++++++
 tb/tb_polar_to_xy_15.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_to_xy_15.sv
// polar_to_xy_15: sequential polar-to-Cartesian converter (shared shift-add multiplier, Q1.16 sine LUT).
// Optional macro POLAR_XY_ROUND_EN selects round-half-up magnitudes instead of truncation.
module polar_to_xy_15 #(
   parameter int R_WIDTH   = 8,
   parameter int FRAC_BITS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [R_WIDTH-1:0]        r,
   input  logic [4:0]                angle_idx,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [R_WIDTH:0]   x,
   output logic signed [R_WIDTH:0]   y,
   output logic                      out_err
);
   localparam int PW     = R_WIDTH + FRAC_BITS + 1;
   localparam int CW     = FRAC_BITS + 1;
   localparam int CNT_W  = (R_WIDTH > 1) ? $clog2(R_WIDTH) : 1;
   localparam int DROP   = 16 - FRAC_BITS;
   localparam int RND_SH = (FRAC_BITS < 16) ? 15 - FRAC_BITS : 0;
   localparam logic [17:0]      RND_ADD = (FRAC_BITS < 16) ? (18'd1 << RND_SH) : 18'd0;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(R_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL_X, MUL_Y, DONE} state_t;
   state_t state, state_nxt;

   function automatic logic [16:0] sin_lut(input logic [2:0] k);
      case (k)
         3'd0:    sin_lut = 17'd0;
         3'd1:    sin_lut = 17'd16962;
         3'd2:    sin_lut = 17'd32768;
         3'd3:    sin_lut = 17'd46341;
         3'd4:    sin_lut = 17'd56756;
         3'd5:    sin_lut = 17'd63303;
         default: sin_lut = 17'd65536;
      endcase
   endfunction

   function automatic logic [CW-1:0] coef_of(input logic [2:0] k);
      logic [17:0] t;
      t = ({1'b0, sin_lut(k)} + RND_ADD) >> DROP;
      coef_of = t[CW-1:0];
   endfunction

   function automatic logic [R_WIDTH:0] mag_of(input logic [PW-1:0] p);
      logic [PW-1:0] t;
`ifdef POLAR_XY_ROUND_EN
      t = (p + (PW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
`else
      t = p >> FRAC_BITS;
`endif
      mag_of = t[R_WIDTH:0];
   endfunction

   // Sign goes on after the magnitude is final, so a zero never becomes -0.
   function automatic logic signed [R_WIDTH:0] apply_sign(input logic [R_WIDTH:0] mag,
                                                          input logic neg);
      apply_sign = (neg && (mag != '0)) ? -$signed(mag) : $signed(mag);
   endfunction

   logic [R_WIDTH-1:0] r_q;
   logic [CNT_W-1:0]   cnt;
   logic [PW-1:0]      acc, acc_nxt, addend;
   logic [CW-1:0]      cx, cy, coef_cur, s_in, c_in;
   logic               negx, negy, last, idx_bad;
   logic [4:0]         quo;
   logic [1:0]         q_in;
   logic [2:0]         m_in;

   always_comb begin
      quo      = angle_idx / 5'd6;
      q_in     = quo[1:0];
      m_in     = 3'(angle_idx - quo * 5'd6);
      idx_bad  = (angle_idx >= 5'd24);
      s_in     = coef_of(m_in);
      c_in     = coef_of(3'd6 - m_in);
      coef_cur = (state == MUL_Y) ? cy : cx;
      addend   = PW'(coef_cur) << cnt;
      acc_nxt  = r_q[cnt] ? (acc + addend) : acc;
      last     = (cnt == LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = idx_bad ? DONE : MUL_X;
         MUL_X:   if (last) state_nxt = MUL_Y;
         MUL_Y:   if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Datapath: latch operands at accept, then one multiplier bit of r per clock, LSB first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q     <= '0;
         cnt     <= '0;
         acc     <= '0;
         cx      <= '0;
         cy      <= '0;
         negx    <= 1'b0;
         negy    <= 1'b0;
         x       <= '0;
         y       <= '0;
         out_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               r_q     <= r;
               cnt     <= '0;
               acc     <= '0;
               x       <= '0;
               y       <= '0;
               out_err <= idx_bad;
               cx      <= q_in[0] ? s_in : c_in;
               cy      <= q_in[0] ? c_in : s_in;
               negx    <= (q_in == 2'd1) || (q_in == 2'd2);
               negy    <= q_in[1];
            end
            MUL_X, MUL_Y: begin
               if (last) begin
                  if (state == MUL_X) x <= apply_sign(mag_of(acc_nxt), negx);
                  else                y <= apply_sign(mag_of(acc_nxt), negy);
                  acc <= '0;
                  cnt <= '0;
               end else begin
                  acc <= acc_nxt;
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_polar_to_xy_15.sv
// Scoreboard bench for polar_to_xy_15: expectations come from a reference model of the trig scaling.
module tb_polar_to_xy_15;
   localparam int RW = 8;
   localparam int FB = 8;

   typedef struct packed {
      logic signed [RW:0] x;
      logic signed [RW:0] y;
      logic               err;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [RW-1:0]        r;
   logic [4:0]           angle_idx;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [RW:0]   x;
   logic signed [RW:0]   y;
   logic                 out_err;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   t_acc = 0;
   logic signed [RW:0] obs_x, obs_y;
   exp_t sb[$];

   polar_to_xy_15 #(.R_WIDTH(RW), .FRAC_BITS(FB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .r(r), .angle_idx(angle_idx), .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .y(y), .out_err(out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lut(input int k);
      case (k)
         0: return 0;
         1: return 16962;
         2: return 32768;
         3: return 46341;
         4: return 56756;
         5: return 63303;
         default: return 65536;
      endcase
   endfunction

   function automatic int coefm(input int k);
      if (FB == 16) return lut(k);
      return (lut(k) + (1 << (15 - FB))) >> (16 - FB);
   endfunction

   function automatic exp_t model(input int rv, input int iv);
      exp_t e;
      int q, m, s, c, ax, ay, mx, my, rnd;
`ifdef POLAR_XY_ROUND_EN
      rnd = 1 << (FB - 1);
`else
      rnd = 0;
`endif
      if (iv >= 24) begin
         e.x = '0; e.y = '0; e.err = 1'b1;
         return e;
      end
      q = iv / 6; m = iv % 6;
      s = coefm(m); c = coefm(6 - m);
      ax = (q == 0 || q == 2) ? c : s;
      ay = (q == 0 || q == 2) ? s : c;
      mx = (rv * ax + rnd) >> FB;
      my = (rv * ay + rnd) >> FB;
      if (q == 1 || q == 2) mx = -mx;
      if (q >= 2) my = -my;
      e.x = mx[RW:0]; e.y = my[RW:0]; e.err = 1'b0;
      return e;
   endfunction

   task automatic send(input logic [RW-1:0] rv, input logic [4:0] iv);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      if (in_ready !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL send_wait in_ready=%b required 1", in_ready);
         return;
      end
      in_valid = 1'b1; r = rv; angle_idx = iv;
      sb.push_back(model(int'(rv), int'(iv)));
      @(posedge clk); #1;
      t_acc = cyc;
      in_valid = 1'b0;
      r = RW'($urandom);
      angle_idx = 5'($urandom);
   endtask

   task automatic recv(input int exp_lat, input string nm);
      int n;
      exp_t e;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s timeout out_valid=%b required 1", nm, out_valid);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s unexpected output x=%0d y=%0d required none", nm, x, y);
         return;
      end
      e = sb.pop_front();
      if (exp_lat >= 0) begin
         vectors++;
         if (cyc - t_acc !== exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency got %0d required %0d", nm, cyc - t_acc, exp_lat);
         end
      end
      vectors++;
      if (x !== e.x || y !== e.y || out_err !== e.err) begin
         miscompares++;
         $display("FAIL %s x=%0d y=%0d err=%b required x=%0d y=%0d err=%b",
                  nm, x, y, out_err, e.x, e.y, e.err);
      end
      obs_x = x; obs_y = y;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || x !== '0 || y !== '0 || out_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state out_valid=%b x=%0d y=%0d err=%b required 0 0 0 0",
                  out_valid, x, y, out_err);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic;
      send(8'd200, 5'd2);
      recv(2 * RW, "deg30");
      vectors++;
      if (obs_x !== 9'sd173 || obs_y !== 9'sd100) begin
         miscompares++;
         $display("FAIL deg30_const x=%0d y=%0d required 173 100", obs_x, obs_y);
      end
      send(8'd200, 5'd8);
      recv(2 * RW, "deg120");
      vectors++;
      if (obs_x !== -9'sd100 || obs_y !== 9'sd173) begin
         miscompares++;
         $display("FAIL deg120_const x=%0d y=%0d required -100 173", obs_x, obs_y);
      end
      send(8'd255, 5'd18);
      recv(2 * RW, "deg270");
      send(8'd100, 5'd3);
      recv(2 * RW, "deg45");
      vectors++;
`ifdef POLAR_XY_ROUND_EN
      if (obs_x !== 9'sd71 || obs_y !== 9'sd71) begin
         miscompares++;
         $display("FAIL deg45_const x=%0d y=%0d required 71 71", obs_x, obs_y);
      end
`else
      if (obs_x !== 9'sd70 || obs_y !== 9'sd70) begin
         miscompares++;
         $display("FAIL deg45_const x=%0d y=%0d required 70 70", obs_x, obs_y);
      end
`endif
      send(8'd0, 5'd13);
      recv(2 * RW, "r_zero");
      send(8'd255, 5'd12);
      recv(2 * RW, "deg180");
   endtask

   task automatic test_err;
      send(8'd77, 5'd24);
      recv(0, "idx24");
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idx24_release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      send(8'd200, 5'd31);
      recv(0, "idx31");
      send(8'd10, 5'd0);
      recv(2 * RW, "after_err");
   endtask

   task automatic test_backpressure;
      logic signed [RW:0] hx, hy;
      int n, bad;
      send(8'd200, 5'd2);
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      hx = x; hy = y;
      in_valid = 1'b1; r = 8'd50; angle_idx = 5'd5;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || x !== hx || y !== hy) bad++;
      end
      in_valid = 1'b0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL hold_stable unstable_cycles=%0d required 0", bad);
      end
      recv(-1, "hold_value");
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL hold_ignored_req spurious_cycles=%0d required 0", bad);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 12; i++) begin
         send(RW'($urandom), 5'($urandom_range(0, 31)));
         recv(-1, "random");
      end
   endtask

   task automatic test_reset_abort;
      int bad;
      send(8'd255, 5'd1);
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (sb.size() > 0 && x !== sb[0].x) begin
         miscompares++;
         $display("FAIL abort_x_ready x=%0d required %0d", x, sb[0].x);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || x !== '0 || y !== '0 || out_err !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_async out_valid=%b x=%0d y=%0d err=%b required 0 0 0 0",
                  out_valid, x, y, out_err);
      end
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_in_ready in_ready=%b required 1", in_ready);
      end
      bad = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL abort_stale spurious_cycles=%0d required 0", bad);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; r = '0; angle_idx = '0;
      obs_x = '0; obs_y = '0;
      test_reset;
      test_basic;
      test_err;
      test_backpressure;
      test_back_to_back;
      test_reset_abort;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
